dm_access_unit: RTL and testbench
=================================

# dm_access_unit

Load/store alignment and handshake stage between the CPU memory stage and the data-memory SRAM wrapper (14-bit word address, active-low 4-bit byte write enable, 1-cycle synchronous read). It converts byte-addressed RV32I loads and stores into SRAM word accesses. Stores get per-byte enables and lane-replicated data. Load data is extracted and sign- or zero-extended one cycle later. Misaligned and illegal accesses are flagged, and response backpressure is handled by replaying the in-flight address.

## Interface
Parameters:
- ADDR_W, 14, SRAM word-address width; byte address bits [ADDR_W+1:2] select the word.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  CPU presents an access.
- req_ready  out  1  access accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response for oldest accepted access.
- rsp_ready  in  1  CPU consumes response.
- rsp_rdata  out  32  aligned and extended load data; 0 for stores and errors.
- rsp_err  out  1  access was misaligned or had illegal funct3.
- DM_A  out  ADDR_W  SRAM word address.
- DM_WEB  out  4  SRAM byte write enables, active low; bit i = byte lane i.
- DM_DI  out  32  SRAM write data.
- DM_DO  in  32  SRAM read data, valid the cycle after the address.

## Operation
- One in-flight register S1: s1_valid, s1_we, s1_funct3, s1_off (addr[1:0]), s1_err, s1_addr (word).
- Error check at acceptance:
  - Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0.
  - Illegal: load funct3 011/110/111, store funct3 >=011.
  - err = misaligned || illegal.
- Accept cycle:
  - DM_A = req_addr[ADDR_W+1:2].
  - Store with !err: DM_WEB clears lanes; SB clears bit off; SH clears {off+1,off}; SW gives 0000.
  - All other cases: DM_WEB = 1111.
  - DM_DI: SB = {4{wdata[7:0]}}, SH = {2{wdata[15:0]}}, SW = wdata.
- Response from S1 and DM_DO, combinational:
  - rsp_valid = s1_valid.
  - Load without error: select byte at s1_off or halfword at s1_off[1], then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes the word.
  - Store or error: rsp_rdata = 0; rsp_err = s1_err.
- req_ready = !s1_valid || rsp_ready. Full pipelining: one access per cycle while rsp_ready=1.
- Stall (s1_valid && !rsp_ready):
  - DM_A = s1_addr, DM_WEB = 1111, DM_DI = 0.
  - The SRAM re-reads the same word, so DM_DO stays stable.
  - No store is ever written twice.
- Idle (no accept, no stall): DM_A = s1_addr, DM_WEB = 1111, DM_DI = 0.
- S1 update each edge:
  - If accepting, load request fields and set s1_valid=1.
  - Else if rsp_ready, clear s1_valid.
  - Otherwise hold.

## Timing
- Reset: s1_valid=0, s1_addr=0. Outputs after reset edge: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1, DM_WEB=1111, DM_A=0, DM_DI=0.
- Latency: response valid exactly 1 cycle after acceptance when not stalled.
- Store writes SRAM at the accept edge; a load to the same word accepted the next cycle returns new data.
- Simultaneous response consume and new accept: S1 is replaced the same edge with no bubble.
- rst asserted mid-stall: S1 is dropped and no response is produced. An uncommitted store (not yet at accept edge) is not written.
- DM_WEB is never low outside an accept cycle.

## Test plan
- Reset then idle: DM_WEB=1111, rsp_valid=0, req_ready=1 for 5 cycles.
- SW 0xDEADBEEF @0x10, then LB @0x13, LBU @0x13, LH @0x12, LHU @0x12, LW @0x10 back-to-back, rsp_ready=1:
  - Store accept: DM_WEB=0000, DM_A=4.
  - Responses at cycles 2..6: 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD, 0xDEADBEEF.
- SB 0x5A @0x21: DM_WEB=1101, DM_DI=0x5A5A5A5A; subsequent LW @0x20 returns byte1=0x5A with other bytes unchanged.
- SH @0x31: DM_WEB=1111, rsp_err=1, rsp_rdata=0; LW @0x30 returns prior contents. Load funct3=011 gives rsp_err=1.
- Backpressure:
  - LW @0x40 accepted, rsp_ready=0 for 3 cycles: rsp_rdata stable, req_ready=0, DM_A=0x10, DM_WEB=1111.
  - A pending SW request is not accepted until rsp_ready=1, then issues the next cycle.
- rst during stall: rsp_valid=0 the next cycle and the stalled load response is never delivered.

Source files
------------

// File: rtl/dm_access_unit.sv
// Load/store alignment stage between the CPU memory stage and the data SRAM.
// Byte-addressed RV32I accesses become word accesses; load data is extended one cycle later.
module dm_access_unit #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] DM_A,
  output logic [3:0]        DM_WEB,
  output logic [31:0]       DM_DI,
  input  logic [31:0]       DM_DO
);

  logic              s1_valid;
  logic              s1_we;
  logic              s1_err;
  logic [2:0]        s1_funct3;
  logic [1:0]        s1_off;
  logic [ADDR_W-1:0] s1_addr;

  logic              accept;
  logic              misaligned;
  logic              illegal;
  logic              err;
  logic [1:0]        off;
  logic [3:0]        web_lanes;
  logic [31:0]       wdata_rep;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              unused_addr_hi;

  assign off            = req_addr[1:0];
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_ready = !s1_valid || rsp_ready;
  // A request seen while rst is high never commits, so no store slips into the SRAM.
  assign accept    = req_valid && req_ready && !rst;

  always_comb begin
    illegal = req_we ? (req_funct3 > 3'd2)
                     : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
    err = misaligned || illegal;
  end

  always_comb begin
    web_lanes = '1;
    wdata_rep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        web_lanes[off] = 1'b0;
        wdata_rep      = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        web_lanes[{off[1], 1'b0}] = 1'b0;
        web_lanes[{off[1], 1'b1}] = 1'b0;
        wdata_rep                 = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        web_lanes = '0;
        wdata_rep = req_wdata;
      end
      default: begin
        web_lanes = '1;
        wdata_rep = req_wdata;
      end
    endcase
  end

  // Outside an accept the SRAM re-reads the held word, keeping DM_DO stable through a stall.
  always_comb begin
    DM_A   = s1_addr;
    DM_WEB = '1;
    DM_DI  = '0;
    if (accept) begin
      DM_A  = req_addr[ADDR_W+1:2];
      DM_DI = wdata_rep;
      if (req_we && !err) begin
        DM_WEB = web_lanes;
      end
    end
  end

  assign byte_sel = DM_DO[{s1_off, 3'b000} +: 8];
  assign half_sel = s1_off[1] ? DM_DO[31:16] : DM_DO[15:0];

  always_comb begin
    rsp_valid = s1_valid;
    rsp_err   = s1_valid && s1_err;
    rsp_rdata = '0;
    if (s1_valid && !s1_we && !s1_err) begin
      case (s1_funct3)
        3'b000:  rsp_rdata = {{24{byte_sel[7]}}, byte_sel};
        3'b001:  rsp_rdata = {{16{half_sel[15]}}, half_sel};
        3'b010:  rsp_rdata = DM_DO;
        3'b100:  rsp_rdata = {24'd0, byte_sel};
        3'b101:  rsp_rdata = {16'd0, half_sel};
        default: rsp_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_we     <= 1'b0;
      s1_err    <= 1'b0;
      s1_funct3 <= '0;
      s1_off    <= '0;
      s1_addr   <= '0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_we     <= req_we;
      s1_err    <= err;
      s1_funct3 <= req_funct3;
      s1_off    <= off;
      s1_addr   <= req_addr[ADDR_W+1:2];
    end else if (rsp_ready) begin
      s1_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit with a behavioural 1-cycle SRAM.
module tb_dm_access_unit;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = '0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] DM_A;
  logic [3:0]        DM_WEB;
  logic [31:0]       DM_DI;
  logic [31:0]       DM_DO;

  dm_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .DM_A(DM_A), .DM_WEB(DM_WEB), .DM_DI(DM_DI), .DM_DO(DM_DO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          strict;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          mon_en = 0;
  bit          rand_bp = 0;
  logic        init_mem = 1'b1;
  logic [31:0] mem [0:255];
  logic [31:0] shadow [0:255];

  function automatic logic [31:0] pat(input int unsigned i);
    logic [7:0] b;
    b = i[7:0];
    return {8'hA5, b, ~b, 8'h3C};
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (!DM_WEB[b]) mem[DM_A[7:0]][8*b +: 8] <= DM_DI[8*b +: 8];
    end
    DM_DO <= mem[DM_A[7:0]];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic m_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_web(input logic we, input logic [2:0] f3, input logic [1:0] off, input logic e);
    if (!we || e) return 4'b1111;
    case (f3)
      3'd0:    return ~(4'b0001 << off);
      3'd1:    return (off == 2'd2) ? 4'b0011 : 4'b1100;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] m_di(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'd0:    return {w[7:0], w[7:0], w[7:0], w[7:0]};
      3'd1:    return {w[15:0], w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] sb_w, sh_w;
    logic [7:0]  b;
    logic [15:0] h;
    sb_w = word >> (8 * int'(off));
    sh_w = word >> (off[1] ? 16 : 0);
    b = sb_w[7:0];
    h = sh_w[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'd0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'd0, h};
      default: return word;
    endcase
  endfunction

  function automatic void shadow_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int i;
    i = int'(a[9:2]);
    case (f3)
      3'd0:    shadow[i][8 * int'(a[1:0]) +: 8] = w[7:0];
      3'd1:    shadow[i][(a[1] ? 16 : 0) +: 16] = w[15:0];
      default: shadow[i] = w;
    endcase
  endfunction

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (DM_WEB !== 4'hF && !(req_valid === 1'b1 && req_ready === 1'b1 && rst === 1'b0)) begin
        miscompares++;
        $display("FAIL web_outside_accept: DM_WEB=%b expected 1111 (cycle %0d)", DM_WEB, cyc);
      end
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rsp: rdata=%h err=%b with nothing outstanding", rsp_rdata, rsp_err);
        end else begin
          mon_e = sb.pop_front();
          if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err) begin
            miscompares++;
            $display("FAIL rsp_data: got rdata=%h err=%b expected rdata=%h err=%b",
                     rsp_rdata, rsp_err, mon_e.rdata, mon_e.err);
          end
          if (mon_e.strict) begin
            vectors++;
            if (cyc != mon_e.acc + 1) begin
              miscompares++;
              $display("FAIL rsp_latency: got %0d cycles expected 1", cyc - mon_e.acc);
            end
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] w, input bit ovr, input logic [31:0] ovr_rd);
    exp_t x;
    logic e;
    int n;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = w;
    n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: req_ready=%b expected 1 within 50 cycles", req_ready);
      req_valid = 1'b0;
      return;
    end
    e = m_err(we, f3, a);
    vectors++;
    if (DM_WEB !== m_web(we, f3, a[1:0], e) || DM_A !== a[ADDR_W+1:2]) begin
      miscompares++;
      $display("FAIL accept_ctrl: DM_WEB=%b DM_A=%h expected %b %h",
               DM_WEB, DM_A, m_web(we, f3, a[1:0], e), a[ADDR_W+1:2]);
    end
    if (we && !e) begin
      vectors++;
      if (DM_DI !== m_di(f3, w)) begin
        miscompares++;
        $display("FAIL accept_di: DM_DI=%h expected %h", DM_DI, m_di(f3, w));
      end
    end
    x.err    = e;
    x.rdata  = (we || e) ? 32'd0 : (ovr ? ovr_rd : m_load(shadow[a[9:2]], f3, a[1:0]));
    x.acc    = cyc;
    x.strict = !rand_bp && rsp_ready;
    sb.push_back(x);
    if (we && !e) shadow_store(f3, a, w);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; init_mem = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; init_mem = 1'b0;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if ({req_ready, rsp_valid, rsp_err, DM_WEB} !== 7'b100_1111) begin
        miscompares++;
        $display("FAIL reset_ctrl: ready=%b valid=%b err=%b web=%b expected 1 0 0 1111",
                 req_ready, rsp_valid, rsp_err, DM_WEB);
      end
      vectors++;
      if (DM_A !== '0 || DM_DI !== '0 || rsp_rdata !== '0) begin
        miscompares++;
        $display("FAIL reset_data: DM_A=%h DM_DI=%h rdata=%h expected all 0", DM_A, DM_DI, rsp_rdata);
      end
    end
    @(posedge clk); #1;
    mon_en = 1;
  endtask

  task automatic test_basic();
    rsp_ready = 1'b1;
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0);
    do_req(1'b0, 3'd0, 32'h13, 32'h0, 1, 32'hFFFFFFDE);
    do_req(1'b0, 3'd4, 32'h13, 32'h0, 1, 32'h000000DE);
    do_req(1'b0, 3'd1, 32'h12, 32'h0, 1, 32'hFFFFDEAD);
    do_req(1'b0, 3'd5, 32'h12, 32'h0, 1, 32'h0000DEAD);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 1, 32'hDEADBEEF);
    drain();
  endtask

  task automatic test_subword();
    do_req(1'b1, 3'd0, 32'h21, 32'hFFFFFF5A, 0, 32'h0);
    do_req(1'b0, 3'd2, 32'h20, 32'h0, 0, 32'h0);
    do_req(1'b1, 3'd1, 32'h26, 32'h1234BEEF, 0, 32'h0);
    do_req(1'b0, 3'd5, 32'h26, 32'h0, 0, 32'h0);
    do_req(1'b0, 3'd1, 32'h26, 32'h0, 0, 32'h0);
    do_req(1'b1, 3'd0, 32'h2B, 32'h00000081, 0, 32'h0);
    do_req(1'b0, 3'd0, 32'h2B, 32'h0, 0, 32'h0);
    do_req(1'b0, 3'd0, 32'h21, 32'h0, 0, 32'h0);
    drain();
  endtask

  task automatic test_errors();
    do_req(1'b1, 3'd1, 32'h31, 32'h0000FFFF, 0, 32'h0);
    do_req(1'b0, 3'd2, 32'h30, 32'h0, 0, 32'h0);
    do_req(1'b0, 3'd3, 32'h30, 32'h0, 0, 32'h0);
    do_req(1'b0, 3'd6, 32'h30, 32'h0, 0, 32'h0);
    do_req(1'b0, 3'd2, 32'h32, 32'h0, 0, 32'h0);
    do_req(1'b0, 3'd5, 32'h33, 32'h0, 0, 32'h0);
    do_req(1'b1, 3'd3, 32'h30, 32'h11111111, 0, 32'h0);
    do_req(1'b1, 3'd4, 32'h30, 32'h22222222, 0, 32'h0);
    do_req(1'b1, 3'd2, 32'h36, 32'h33333333, 0, 32'h0);
    do_req(1'b0, 3'd2, 32'h30, 32'h0, 0, 32'h0);
    do_req(1'b0, 3'd2, 32'h34, 32'h0, 0, 32'h0);
    drain();
  endtask

  task automatic test_backpressure();
    exp_t x;
    logic [31:0] held;
    rsp_ready = 1'b0;
    held = m_load(shadow[16], 3'd2, 2'd0);
    do_req(1'b0, 3'd2, 32'h40, 32'h0, 0, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h44; req_wdata = 32'hCAFEF00D;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, req_ready, DM_WEB} !== 6'b10_1111 || DM_A !== 14'h10 || DM_DI !== '0) begin
        miscompares++;
        $display("FAIL stall_ctrl: valid=%b ready=%b web=%b A=%h DI=%h expected 1 0 1111 0010 0",
                 rsp_valid, req_ready, DM_WEB, DM_A, DM_DI);
      end
      vectors++;
      if (rsp_rdata !== held) begin
        miscompares++;
        $display("FAIL stall_rdata: got %h expected %h", rsp_rdata, held);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || DM_WEB !== 4'b0000 || DM_A !== 14'h11 || DM_DI !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL release_store: ready=%b web=%b A=%h DI=%h expected 1 0000 0011 cafef00d",
               req_ready, DM_WEB, DM_A, DM_DI);
    end
    x.rdata = 32'd0; x.err = 1'b0; x.acc = cyc; x.strict = 1'b1;
    sb.push_back(x);
    shadow_store(3'd2, 32'h44, 32'hCAFEF00D);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();
    do_req(1'b0, 3'd2, 32'h44, 32'h0, 0, 32'h0);
    drain();
  endtask

  task automatic test_reset_stall();
    rsp_ready = 1'b0;
    do_req(1'b0, 3'd2, 32'h50, 32'h0, 0, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h50; req_wdata = 32'h11111111;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_rst_stall: ready=%b valid=%b expected 0 1", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (DM_WEB !== 4'hF) begin
      miscompares++;
      $display("FAIL rst_web: DM_WEB=%b expected 1111", DM_WEB);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    sb.delete();
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL post_rst: valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
      end
      @(posedge clk); #1;
    end
    do_req(1'b0, 3'd2, 32'h50, 32'h0, 0, 32'h0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    rand_bp = 1;
    for (int i = 0; i < 60; i++) begin
      we = ($urandom_range(0, 1) == 1);
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h80 + 32'($urandom_range(0, 63));
      do_req(we, f3, a, $urandom, 0, 32'h0);
    end
    rand_bp = 0;
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    drain();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
    test_reset();
    test_basic();
    test_subword();
    test_errors();
    test_backpressure();
    test_reset_stall();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
